mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester controller for the single-ported unified instruction/data memory of the multi-cycle MIPS core. Arbitrates between the instruction-fetch port and the load/store port, sequences each access through the memory's one-cycle registered read latency, and returns registered read data with a valid pulse. Blocks stores to the instruction-ROM region (address bit 15 = 0) and flags them.

## Interface
- DATA_WIDTH, 32, word width of memory data.
- ADDR_WIDTH, 16, memory byte/word address width; bit ADDR_WIDTH-1 selects ROM (0) or RAM (1).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  combinational one-cycle accept of fetch request.
- if_rvalid  out  1  registered one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_WIDTH  fetched word, held until next fetch completes.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_gnt  out  1  combinational one-cycle accept of data request.
- d_rvalid  out  1  registered one-cycle completion pulse (loads and stores).
- d_rdata  out  DATA_WIDTH  loaded word; unchanged by stores.
- d_err  out  1  pulses with d_rvalid when a store targeted ROM.
- mem_addr  out  ADDR_WIDTH  address to memory.
- mem_we  out  1  memory write enable.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory read data, valid one cycle after address.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM: IDLE -> ACCESS -> RESP -> IDLE. No other states.
- IDLE: if any request, grant exactly one (gnt high this cycle), latch requester id, addr, we, wdata at the edge, go ACCESS. No request: stay.
- Arbitration: round-robin on a `last` flag. Only one requesting -> it wins. Both -> the one not served last. Reset sets last = DATA, so fetch wins the first tie.
- ACCESS: mem_addr = latched addr; mem_we = latched we AND addr[ADDR_WIDTH-1]; mem_wd = latched wdata. Go RESP.
- RESP: mem_addr still held, mem_we = 0; at the edge capture mem_rd into the winner's rdata (loads/fetches only), set winner's rvalid for one cycle, d_err = 1 if the op was a store with addr[ADDR_WIDTH-1] = 0, update last, go IDLE.
- ROM store: no memory write occurs; transaction otherwise completes normally.
- Loads from ROM region are legal (constant tables).
- Fetch port is read-only by construction.

## Timing
- Reset (rst_n low at an edge): state IDLE, last = DATA, all outputs 0 (if_rvalid, d_rvalid, d_err, busy, mem_we, mem_addr, mem_wd, if_rdata, d_rdata). Gnt outputs are 0 while rst_n is low.
- Latency: gnt in cycle T, memory sampled at end of T+1, rvalid/rdata in T+3. Throughput one access per 3 cycles.
- Gnt only asserted in IDLE; requests arriving in ACCESS/RESP wait.
- Requester may drop req before gnt without penalty; req and fields after gnt are ignored.
- Simultaneous rvalid pulse and new request: the new request is granted in that same cycle (state already IDLE).
- Reset mid-transaction: access abandoned, no rvalid, no d_err, mem_we low from the next cycle.
- Both ports' rvalid are never high in the same cycle.

## Structure
- Package mips_mem_pkg: state enum {IDLE, ACCESS, RESP}; requester id enum {REQ_IF, REQ_D}; localparam ROM_SEL_BIT = ADDR_WIDTH-1.
- One sub-module: rr_arbiter_2 (two-input round-robin grant from req pair + last flag, combinational).
- Top instantiates rr_arbiter_2 plus FSM and latch registers; intended size ~150-250 lines RTL.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with if_req = d_req = 1 -> no gnt; all outputs 0; first cycle after release if_gnt = 1.
- Fetch: if_addr = 0x0004, memory returns 0x8C220000 -> if_gnt at T, mem_addr = 0x0004 at T+1, if_rvalid = 1 and if_rdata = 0x8C220000 at T+3.
- Contention: both req continuously -> grants alternate IF, D, IF, D; each gnt spaced 3 cycles.
- Store to RAM: d_we = 1, d_addr = 0x8010, d_wdata = 0xDEADBEEF -> mem_we = 1 only in T+1; subsequent load of 0x8010 returns 0xDEADBEEF; d_err = 0.
- Store to ROM: d_addr = 0x0010 -> mem_we never high; d_rvalid and d_err both 1 at T+3.
- Reset mid-access: assert rst_n = 0 during ACCESS of a store -> no rvalid, mem_we = 0 next cycle, state IDLE.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port controller.
package mips_mem_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH = 16;

    // Top address bit: 0 = instruction ROM, 1 = data RAM.
    localparam int ROM_SEL_BIT = MEM_ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter: a lone requester always wins, and on a tie the
// requester that was not served most recently wins.
module rr_arbiter_2
    import mips_mem_pkg::*;
(
    input  logic    req_if,
    input  logic    req_d,
    input  req_id_t last,
    output logic    gnt_if,
    output logic    gnt_d
);

    // Combinational grant from the request pair and the last-served flag.
    always_comb begin
        gnt_if = req_if & (~req_d  | (last == REQ_D));
        gnt_d  = req_d  & (~req_if | (last == REQ_IF));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Controller for the single-ported unified memory of the multi-cycle MIPS core.
// Arbitrates fetch and load/store requests, walks each one through the memory's
// registered read latency and returns registered data with a one-cycle valid.
// Stores into the ROM half of the address space are suppressed and flagged.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  busy
);

    // ROM/RAM select bit, tracking ADDR_WIDTH if the port is ever resized.
    localparam int SEL_BIT = ROM_SEL_BIT + (ADDR_WIDTH - MEM_ADDR_WIDTH);

    state_t                state_q;
    state_t                state_d;
    req_id_t               last_q;
    req_id_t               id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  arb_if;
    logic                  arb_d;

    rr_arbiter_2 u_arb (
        .req_if (if_req),
        .req_d  (d_req),
        .last   (last_q),
        .gnt_if (arb_if),
        .gnt_d  (arb_d)
    );

    // Next-state logic; grants are only offered from IDLE and never during reset.
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    if_gnt = arb_if;
                    d_gnt  = arb_d;
                    if (arb_if || arb_d) begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning request; its fields are ignored after the grant cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q    <= REQ_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (if_gnt) begin
            id_q    <= REQ_IF;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (d_gnt) begin
            id_q    <= REQ_D;
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
        end
    end

    // Response stage: route memory data to the winner, pulse its valid, and
    // record who was served so the next tie goes the other way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q    <= REQ_D;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            if (state_q == RESP) begin
                last_q <= id_q;
                if (id_q == REQ_IF) begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_rd;
                end else begin
                    d_rvalid <= 1'b1;
                    d_err    <= we_q & ~addr_q[SEL_BIT];
                    if (!we_q) begin
                        d_rdata <= mem_rd;
                    end
                end
            end
        end
    end

    // Memory drive: the address is held through ACCESS and RESP; the write strobe
    // is confined to ACCESS and masked for the ROM half.
    always_comb begin
        mem_addr = addr_q;
        mem_wd   = wdata_q;
        mem_we   = (state_q == ACCESS) & we_q & addr_q[SEL_BIT];
        busy     = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter. A transaction-level model
// predicts grants from the round-robin rules and schedules the expected memory
// activity and responses a fixed number of cycles after each grant.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          busy;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Expected observations for one cycle.
    typedef struct {
        bit          rst;
        bit          we;
        bit          achk;
        bit          wchk;
        bit          busy;
        bit          ifv;
        bit          dv;
        bit          derr;
        bit          ld;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] data;
    } slot_t;

    slot_t         sl [8];
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] rd_next;
    logic [DW-1:0] cur_if;
    logic [DW-1:0] cur_d;
    int            cyc;
    int            free_cyc;
    req_id_t       m_last;
    int            n_checks = 0;
    int            n_errors = 0;

    bit            rnd_en = 0;
    bit            want_rst, want_if, want_d, want_d_we, hold_if, hold_d;
    logic [AW-1:0] want_if_addr, want_d_addr;
    logic [DW-1:0] want_d_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15));
        a[ROM_SEL_BIT] = 1'($urandom_range(0, 1));
        return a;
    endfunction

    task automatic cycle();
        slot_t         e;
        bit            idle, eg_if, eg_d, st, ram;
        logic [AW-1:0] a;
        int            s1, s2, s3;
        @(posedge clk);
        #1;
        cyc++;
        mem_rd = rd_next;
        e = sl[cyc % 8];
        if (e.rst) begin
            cur_if = '0;
            cur_d  = '0;
        end
        if (e.ifv) cur_if = e.data;
        if (e.dv && e.ld) cur_d = e.data;
        chk("if_rvalid", 32'(if_rvalid), 32'(e.ifv));
        chk("d_rvalid", 32'(d_rvalid), 32'(e.dv));
        chk("d_err", 32'(d_err), 32'(e.derr));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("if_rdata", if_rdata, cur_if);
        chk("d_rdata", d_rdata, cur_d);
        if (e.achk) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.wchk) chk("mem_wd", mem_wd, e.wd);
        sl[cyc % 8] = '{default: '0};

        if (rnd_en) begin
            want_rst = ($urandom_range(0, 199) == 0);
            if (!want_if && $urandom_range(0, 1) == 1) begin
                want_if      = 1;
                want_if_addr = rnd_addr();
            end
            if (!want_d && $urandom_range(0, 1) == 1) begin
                want_d       = 1;
                want_d_we    = 1'($urandom_range(0, 1));
                want_d_addr  = rnd_addr();
                want_d_wdata = $urandom;
            end
            if (want_if && $urandom_range(0, 15) == 0) want_if = 0;
            if (want_d && $urandom_range(0, 15) == 0) want_d = 0;
        end
        rst_n   = !want_rst;
        if_req  = want_if;
        if_addr = want_if ? want_if_addr : AW'($urandom);
        d_req   = want_d;
        d_we    = want_d ? want_d_we : 1'($urandom);
        d_addr  = want_d ? want_d_addr : AW'($urandom);
        d_wdata = want_d ? want_d_wdata : $urandom;
        #1;

        idle  = (cyc >= free_cyc);
        eg_if = rst_n && idle && if_req && (!d_req || m_last == REQ_D);
        eg_d  = rst_n && idle && d_req && (!if_req || m_last == REQ_IF);
        chk("if_gnt", 32'(if_gnt), 32'(eg_if));
        chk("d_gnt", 32'(d_gnt), 32'(eg_d));
        s1 = (cyc + 1) % 8;
        s2 = (cyc + 2) % 8;
        s3 = (cyc + 3) % 8;
        if (!rst_n) begin
            sl[s1] = '{default: '0};
            sl[s2] = '{default: '0};
            sl[s3] = '{default: '0};
            sl[s1].rst  = 1;
            sl[s1].achk = 1;
            sl[s1].wchk = 1;
            free_cyc = cyc + 1;
            m_last   = REQ_D;
        end else if (eg_if || eg_d) begin
            a   = eg_if ? if_addr : d_addr;
            st  = eg_d && d_we;
            ram = a[ROM_SEL_BIT];
            sl[s1].achk = 1;
            sl[s1].addr = a;
            sl[s1].busy = 1;
            sl[s1].we   = st && ram;
            sl[s1].wchk = st;
            sl[s1].wd   = d_wdata;
            sl[s2].achk = 1;
            sl[s2].addr = a;
            sl[s2].busy = 1;
            sl[s3].ifv  = eg_if;
            sl[s3].dv   = eg_d;
            sl[s3].derr = st && !ram;
            sl[s3].ld   = eg_d && !st;
            sl[s3].data = ref_mem[a];
            if (st && ram) ref_mem[a] = d_wdata;
            free_cyc = cyc + 3;
            m_last   = eg_if ? REQ_IF : REQ_D;
            if (eg_if && !hold_if) want_if = 0;
            if (eg_d && !hold_d) want_d = 0;
        end

        rd_next = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wd;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'h8C22_0000;
        ref_mem[4] = 32'h8C22_0000;
        for (int i = 0; i < 8; i++) sl[i] = '{default: '0};
        rst_n = 0; if_req = 1; d_req = 1; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rd = '0;
        hold_if = 0; hold_d = 0;
        @(posedge clk);
        cyc = 0; free_cyc = 0; m_last = REQ_D; rd_next = '0;
        cur_if = '0; cur_d = '0;
        sl[1].rst = 1; sl[1].achk = 1; sl[1].wchk = 1;

        // reset held with both ports requesting, then fetch wins the first tie
        want_rst = 1;
        want_if = 1; want_if_addr = 16'h0004;
        want_d = 1; want_d_we = 0; want_d_addr = 16'h8010; want_d_wdata = '0;
        run(2);
        want_rst = 0;
        run(8);

        // store to RAM, then read it back
        want_d = 1; want_d_we = 1; want_d_addr = 16'h8010; want_d_wdata = 32'hDEAD_BEEF;
        run(4);
        want_d = 1; want_d_we = 0; want_d_addr = 16'h8010;
        run(4);

        // store to ROM is suppressed and flagged; the location keeps its content
        want_d = 1; want_d_we = 1; want_d_addr = 16'h0010; want_d_wdata = 32'h1234_5678;
        run(4);
        want_d = 1; want_d_we = 0; want_d_addr = 16'h0010;
        run(4);

        // continuous contention alternates the two ports
        hold_if = 1; hold_d = 1;
        want_if = 1; want_if_addr = 16'h0008;
        want_d = 1; want_d_we = 0; want_d_addr = 16'h8004;
        run(13);
        hold_if = 0; hold_d = 0;
        run(10);

        // reset during the ACCESS cycle of a store
        want_d = 1; want_d_we = 1; want_d_addr = 16'h8020; want_d_wdata = 32'hCAFE_F00D;
        cycle();
        want_rst = 1;
        cycle();
        want_rst = 0;
        run(4);
        want_d = 1; want_d_we = 0; want_d_addr = 16'h8020;
        run(5);

        // random traffic with occasional resets
        rnd_en = 1;
        run(3000);
        rnd_en = 0; want_rst = 0; want_if = 0; want_d = 0;
        run(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
